// File: rtl/ldpc_pkg.sv
// Shared types and sizing helpers for the hard-decision LDPC encode/decode pair.
package ldpc_pkg;

  localparam int LDPC_N = 11;
  localparam int LDPC_K = 6;

  typedef enum logic [1:0] {IDLE, SYND, FLIP, DONE} state_t;

  // Iteration counter is at least 1 bit wide so MAX_ITER=0 still yields a legal port.
  function automatic int iter_w(input int max_iter);
    return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  // Row r of the packed P matrix starts at bit r*(N-K).
  function automatic int row_base(input int r, input int m);
    return r * m;
  endfunction

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome of a systematic {info, parity} word against P.
module ldpc_syndrome
  import ldpc_pkg::*;
#(
  parameter int N = LDPC_N,
  parameter int K = LDPC_K
) (
  input  logic [N-1:0]       word,
  input  logic [K*(N-K)-1:0] p,
  output logic [N-K-1:0]     syn
);

  localparam int M = N - K;

  always_comb begin
    syn = word[M-1:0];
    for (int r = 0; r < K; r++) begin
      if (word[M+r]) syn = syn ^ p[row_base(r, M) +: M];
    end
  end

endmodule

// File: rtl/ldpc_bitflip_decode.sv
// Iterative max-count bit-flipping LDPC decoder with valid/ready input and a result strobe.
module ldpc_bitflip_decode
  import ldpc_pkg::*;
#(
  parameter int N        = LDPC_N,
  parameter int K        = LDPC_K,
  parameter int MAX_ITER = 8,
  localparam int M  = N - K,
  localparam int IW = iter_w(MAX_ITER),
  localparam int CW = cnt_w(N - K)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N-1:0]       i_codeword,
  input  logic [K*(N-K)-1:0] generator_p,
  output logic               o_valid,
  output logic [K-1:0]       o_info,
  output logic               o_success,
  output logic [IW-1:0]      o_iters
);

  state_t             state;
  logic [N-1:0]       word_q;
  logic [K*M-1:0]     p_q;
  logic [M-1:0]       syn_q;
  logic [IW-1:0]      iter_q;
  logic [M-1:0]       syn;
  logic [CW-1:0]      cnt [N];
  logic [CW-1:0]      max_cnt;
  logic [N-1:0]       flip_mask;

  ldpc_syndrome #(.N(N), .K(K)) u_syndrome (
    .word (word_q),
    .p    (p_q),
    .syn  (syn)
  );

  // Unsatisfied-check count per bit; every bit tied at the maximum flips together.
  always_comb begin
    max_cnt   = '0;
    flip_mask = '0;
    for (int j = 0; j < M; j++) cnt[j] = CW'(syn_q[j]);
    for (int r = 0; r < K; r++) begin
      cnt[M+r] = '0;
      for (int j = 0; j < M; j++)
        cnt[M+r] = cnt[M+r] + CW'(p_q[row_base(r, M) + j] & syn_q[j]);
    end
    for (int i = 0; i < N; i++) if (cnt[i] > max_cnt) max_cnt = cnt[i];
    for (int i = 0; i < N; i++) flip_mask[i] = (max_cnt != '0) && (cnt[i] == max_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_info    <= '0;
      o_success <= 1'b0;
      o_iters   <= '0;
      word_q    <= '0;
      p_q       <= '0;
      syn_q     <= '0;
      iter_q    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            word_q  <= i_codeword;
            p_q     <= generator_p;
            iter_q  <= '0;
            o_ready <= 1'b0;
            state   <= SYND;
          end
        end
        SYND: begin
          syn_q <= syn;
          if (syn == '0 || iter_q == IW'(MAX_ITER)) begin
            o_valid   <= 1'b1;
            o_success <= (syn == '0);
            o_info    <= word_q[N-1:M];
            o_iters   <= iter_q;
            state     <= DONE;
          end else begin
            state <= FLIP;
          end
        end
        FLIP: begin
          word_q <= word_q ^ flip_mask;
          iter_q <= iter_q + IW'(1);
          state  <= SYND;
        end
        DONE: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_bitflip_decode.sv
// Directed bench for the bit-flip decoder: two instances, MAX_ITER=8 and MAX_ITER=0.
module tb_ldpc_bitflip_decode;

  localparam logic [29:0] P_MAT = {5'b01100, 5'b01010, 5'b01001, 5'b00110, 5'b00101, 5'b00011};
  localparam logic [10:0] CW_CLEAN = 11'b11111101111;
  localparam logic [10:0] CW_ERR   = 11'b11111001111;
  localparam logic [10:0] CW_B     = 11'b10101001000;
  localparam logic [10:0] CW_ZERO  = 11'b00000000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_valid0 = 1'b0;
  logic [10:0] i_codeword = '0;
  logic [29:0] generator_p = P_MAT;
  logic        o_ready, o_valid, o_success;
  logic [5:0]  o_info;
  logic [3:0]  o_iters;
  logic        o_ready0, o_valid0, o_success0;
  logic [5:0]  o_info0;
  logic [0:0]  o_iters0;

  int checks = 0;
  int errors = 0;
  int lat;
  int vcount;

  always #5 clk = ~clk;

  ldpc_bitflip_decode #(.N(11), .K(6), .MAX_ITER(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_codeword(i_codeword), .generator_p(generator_p), .o_valid(o_valid),
    .o_info(o_info), .o_success(o_success), .o_iters(o_iters)
  );

  ldpc_bitflip_decode #(.N(11), .K(6), .MAX_ITER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid0), .o_ready(o_ready0),
    .i_codeword(i_codeword), .generator_p(generator_p), .o_valid(o_valid0),
    .o_info(o_info0), .o_success(o_success0), .o_iters(o_iters0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] encode(input logic [5:0] info);
    logic [4:0] par;
    logic [29:0] pm;
    pm  = P_MAT;
    par = '0;
    for (int r = 0; r < 6; r++)
      for (int j = 0; j < 5; j++)
        par[j] = par[j] ^ (info[r] & pm[r*5 + j]);
    return {info, par};
  endfunction

  // Accept one word on the selected instance and return the accept-to-o_valid latency (-1 on timeout).
  task automatic decode(input bit sel, input logic [10:0] cw, output int l);
    @(negedge clk);
    i_codeword = cw;
    if (sel) i_valid0 = 1'b1; else i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_valid0 = 1'b0;
    l = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((sel ? o_valid0 : o_valid) === 1'b1) begin
        l = c;
        break;
      end
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_info", o_info, 0);
    chk("rst_success", o_success, 0);
    chk("rst_iters", o_iters, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean word
    decode(0, CW_CLEAN, lat);
    chk("clean_lat", lat, 2);
    chk("clean_info", o_info, 6'b111111);
    chk("clean_success", o_success, 1);
    chk("clean_iters", o_iters, 0);
    @(negedge clk);
    chk("clean_valid_pulse", o_valid, 0);

    // Single info-bit error, one flip
    decode(0, CW_ERR, lat);
    chk("err_lat", lat, 4);
    chk("err_info", o_info, 6'b111111);
    chk("err_success", o_success, 1);
    chk("err_iters", o_iters, 1);

    // Zero iteration budget
    decode(1, CW_ERR, lat);
    chk("max0_lat", lat, 2);
    chk("max0_info", o_info0, 6'b111110);
    chk("max0_success", o_success0, 0);
    chk("max0_iters", o_iters0, 0);

    // Handshake: i_valid held high, codeword changed while busy
    @(negedge clk);
    i_codeword = CW_ERR;
    i_valid    = 1'b1;
    @(negedge clk);
    chk("hs_ready_synd1", o_ready, 0);
    i_codeword = CW_B;
    @(negedge clk);
    chk("hs_ready_flip", o_ready, 0);
    i_codeword = CW_ZERO;
    @(negedge clk);
    chk("hs_ready_synd2", o_ready, 0);
    chk("hs_valid_early", o_valid, 0);
    @(negedge clk);
    chk("hs_valid1", o_valid, 1);
    chk("hs_ready_done", o_ready, 0);
    chk("hs_info1", o_info, 6'b111111);
    @(negedge clk);
    chk("hs_ready_idle", o_ready, 1);
    chk("hs_valid_idle", o_valid, 0);
    @(negedge clk);
    chk("hs_ready_synd3", o_ready, 0);
    @(negedge clk);
    chk("hs_valid2", o_valid, 1);
    chk("hs_info2", o_info, 6'b000000);
    chk("hs_success2", o_success, 1);
    chk("hs_iters2", o_iters, 0);
    @(negedge clk);
    i_valid = 1'b0;
    chk("hs_ready_after", o_ready, 1);
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid === 1'b1) vcount++;
    end
    chk("hs_no_extra_valid", vcount, 0);

    // Reset asserted while in FLIP
    decode(0, CW_CLEAN, lat);
    chk("pre_rst_info", o_info, 6'b111111);
    @(negedge clk);
    @(negedge clk);
    i_codeword = CW_ERR;
    i_valid    = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flip_busy", o_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_info", o_info, 0);
    chk("midrst_success", o_success, 0);
    chk("midrst_iters", o_iters, 0);
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid === 1'b1) vcount++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (o_valid === 1'b1) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);
    decode(0, CW_CLEAN, lat);
    chk("postrst_lat", lat, 2);
    chk("postrst_info", o_info, 6'b111111);
    chk("postrst_iters", o_iters, 0);

    // Random info, 0 or 1 info-bit errors
    for (int t = 0; t < 10; t++) begin
      logic [5:0]  info;
      logic [10:0] cw;
      int          e;
      info = 6'($urandom_range(0, 63));
      e    = $urandom_range(0, 6);
      cw   = encode(info);
      if (e < 6) cw[5 + e] = ~cw[5 + e];
      decode(0, cw, lat);
      chk($sformatf("rnd%0d_lat", t), lat, (e < 6) ? 4 : 2);
      chk($sformatf("rnd%0d_info", t), o_info, info);
      chk($sformatf("rnd%0d_success", t), o_success, 1);
      chk($sformatf("rnd%0d_iters", t), o_iters, (e < 6) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_bitflip_decode.md
Name: ldpc_bitflip_decode

Overview:
- Hard-decision LDPC decoder that consumes N-bit codewords produced by `encode` after the channel model. It uses the same systematic generator parity matrix.
- Runs an iterative max-count bit-flipping (Gallager-style) loop until the syndrome is zero or the iteration limit is reached.
- Returns the K information bits plus success and iteration-count status, over a valid/ready handshake.

Parameters:
- N, 11, codeword length in bits.
- K, 6, information length in bits.
- MAX_ITER, 8, maximum flip iterations before declaring failure; 0 is legal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input word present.
- o_ready  out  1  decoder can accept; high only in IDLE.
- i_codeword  in  N  received hard-decision word.
- generator_p  in  K*(N-K)  P matrix; row r = generator_p[r*(N-K) +: N-K].
- o_valid  out  1  single-cycle result strobe.
- o_info  out  K  decoded info bits.
- o_success  out  1  1 = final syndrome zero.
- o_iters  out  $clog2(MAX_ITER+1)  number of flip iterations performed.

Behaviour:
- Codeword layout, shared with `encode`:
  - {info, parity}; info bit r = bit N-K+r, parity bit j = bit j.
  - Parity j = XOR over r of info[r] & P[r][j].
  - Check j covers parity bit j plus every info bit r with P[r][j]=1.
- Reset (async, rst_n low): state=IDLE, o_ready=1, o_valid=0, o_info=0, o_success=0, o_iters=0, internal word/syndrome/counter=0.
- Reset mid-decode aborts immediately; no o_valid is produced.
- Accept: i_valid & o_ready at a clock edge latches i_codeword into word_q and generator_p into p_q. iter_q clears to 0; state goes to SYND.
- i_valid while not ready is ignored. No buffering; the source must hold until accepted.
- SYND (1 cycle):
  - Syndrome s is computed combinationally from word_q/p_q and registered into syn_q.
  - s==0: go to DONE with success=1.
  - Else if iter_q==MAX_ITER: go to DONE with success=0.
  - Else: go to FLIP.
- FLIP (1 cycle):
  - For each bit, count the unsatisfied checks in syn_q that include it (info bit r: popcount(P[r] & syn_q); parity bit j: syn_q[j]).
  - Let m = the maximum count; m≥1 whenever syn_q≠0.
  - Invert every bit whose count == m. All tied bits flip together.
  - iter_q += 1, then go to SYND.
- DONE (1 cycle):
  - o_valid=1; o_info = word_q[N-1:N-K]; o_success and o_iters = iter_q are registered outputs.
  - o_ready=0 in this cycle. Next state is IDLE.
- o_info, o_success and o_iters hold their values until the next DONE. o_valid is high for exactly one cycle per accepted word.
- Latency from the accept edge to o_valid high:
  - 2 cycles for a clean word.
  - 2+2*k cycles for a word converging after k flips.
  - A failing word reports o_iters=MAX_ITER.
- Minimum accept-to-accept spacing is 3 cycles.
- A zero syndrome reached by miscorrection is reported as success; no codeword-level check is made.
- Popcount width is $clog2(N-K+1). All arithmetic is unsigned.

Decomposition:
- ldpc_pkg holds:
  - the N/K defaults;
  - the state enum IDLE/SYND/FLIP/DONE;
  - the ITER_W and CNT_W width functions;
  - the row-slice helper for generator_p shared with `encode`.
- One sub-module, ldpc_syndrome: combinational, (word, p) -> (N-K)-bit syndrome. It is reusable by an `encode` self-check.

Test Plan:
- P rows r0..r5 = 00011, 00101, 00110, 01001, 01010, 01100 are used throughout.
- Clean word: i_codeword=11'b11111101111 (info 111111) -> o_valid 2 cycles after accept; o_info=6'b111111, o_success=1, o_iters=0.
- Info bit 0 error: i_codeword=11'b11111001111 -> syndrome 00011; one flip of bit 5; o_valid 4 cycles after accept; o_info=111111, o_success=1, o_iters=1.
- MAX_ITER=0 with the same erroneous word -> o_valid 2 cycles after accept; o_success=0, o_iters=0, o_info=6'b111110.
- Handshake:
  - i_valid held high continuously -> o_ready low in SYND/FLIP/DONE.
  - A second word is accepted only in IDLE; exactly one o_valid per accepted word.
  - Words changed while o_ready=0 are not decoded.
- Reset: assert rst_n=0 while in FLIP -> all outputs zero with no clock edge needed, o_ready=1; after release, a clean word decodes with o_iters=0.
- Random: encode random info with `encode`, inject 0 or 1 info-bit errors -> o_info matches the original and o_success=1 for every trial.
